// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
package rv32i_fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response, execute redirect, decode handoff.
interface pc_fetch_unit_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        misalign_fault;

    modport master (
        output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, misalign_fault,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_target,
               if_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, misalign_fault,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_target,
               if_ready
    );

endinterface

// File: rtl/pc_fetch_unit_fifo.sv
// Fetch buffer: circular FIFO of {pc, instr} with flush; head is read combinationally.
module fetch_fifo
    import rv32i_fetch_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter type         entry_t = fetch_entry_t
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_push,
    input  entry_t                       i_push_data,
    input  logic                         i_pop,
    input  logic                         i_flush,
    output entry_t                       o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_full,
    output logic                         o_empty
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    entry_t          r_mem [DEPTH];
    logic [PW-1:0]   r_rd;
    logic [PW-1:0]   r_wr;
    logic [CW-1:0]   r_count;
    logic            w_do_push;
    logic            w_do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd];
    // Push into a full buffer is allowed only when the head leaves in the same cycle.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr] <= i_push_data;
                r_wr        <= ptr_inc(r_wr);
            end
            if (w_do_pop) r_rd <= ptr_inc(r_rd);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// RV32I fetch stage: PC, credit-limited imem requests, wrong-path drop after redirect.
// Optional misaligned-redirect trap enabled by defining RV_FETCH_MISALIGN_TRAP_EN.
module pc_fetch_unit
    import rv32i_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    pc_fetch_unit_if.master    bus
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    logic [31:0]   r_pc;
    logic [31:0]   r_rsp_pc;
    logic [CW-1:0] r_out;
    logic [CW-1:0] r_drop;
    logic          r_run;
    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_empty;
    fetch_entry_t  w_head;
    fetch_entry_t  w_push_data;
    logic          w_req_valid;
    logic          w_fire;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_out_next;
    logic [31:0]   w_target;
    logic          w_fault;

`ifdef RV_FETCH_MISALIGN_TRAP_EN
    logic r_fault;

    assign w_target = bus.redirect_target;
    assign w_fault  = r_fault;

    // Sticky until reset; blocks all further requests.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_fault <= 1'b0;
        else if (bus.redirect_valid && (bus.redirect_target[1:0] != 2'b00))
            r_fault <= 1'b1;
    end
`else
    assign w_target = bus.redirect_target & ~32'd3;
    assign w_fault  = 1'b0;
`endif

    // Buffered words plus in-flight requests may never exceed the buffer size.
    assign w_req_valid = r_run && !w_fault &&
                         (((CW+1)'(w_count) + (CW+1)'(r_out)) < (CW+1)'(FIFO_DEPTH));
    assign w_fire      = w_req_valid && bus.imem_req_ready;
    assign w_out_next  = r_out + CW'(w_fire) - CW'(bus.imem_rsp_valid);
    assign w_push      = bus.imem_rsp_valid && !bus.redirect_valid && (r_drop == '0) &&
                         (!w_full || w_pop);
    assign w_pop       = !w_empty && bus.if_ready && !bus.redirect_valid;
    assign w_push_data = '{pc: r_rsp_pc, instr: bus.imem_rsp_data};

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .i_flush     (bus.redirect_valid),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc     <= RESET_PC;
            r_rsp_pc <= RESET_PC;
            r_out    <= '0;
            r_drop   <= '0;
            r_run    <= 1'b0;
        end else begin
            r_run <= 1'b1;
            r_out <= w_out_next;
            if (bus.redirect_valid) begin
                // Everything still in flight after this edge belongs to the old path.
                r_pc     <= w_target;
                r_rsp_pc <= w_target;
                r_drop   <= w_out_next;
            end else begin
                if (w_fire) r_pc <= r_pc + PC_STEP;
                if (w_push) r_rsp_pc <= r_rsp_pc + PC_STEP;
                if (bus.imem_rsp_valid && (r_drop != '0)) r_drop <= r_drop - CW'(1);
            end
        end
    end

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_pc;
    assign bus.if_valid       = !w_empty;
    assign bus.if_instr       = w_head.instr;
    assign bus.if_pc          = w_head.pc;
    assign bus.misalign_fault = w_fault;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: per-cycle vector table plus redirect/stall/wrap sequences.
module tb_pc_fetch_unit;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        redir;
        logic [31:0] tgt;
        logic        exp_rv;
        logic [31:0] exp_addr;
        logic        exp_ifv;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    pc_fetch_unit_if bus ();

    pc_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int    n_total = 0;
    int    n_pass  = 0;
    int    cyc     = 0;
    int    lat     = 1;
    int    fires   = 0;
    mreq_t mq[$];
    vec_t  vecs[16];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, got, exp);
        else n_pass++;
    endtask

    // Memory model: in-order responses, lat cycles after acceptance, word = 0x13 + addr.
    task automatic step();
        logic  f;
        mreq_t e;
        f = bus.imem_req_valid && bus.imem_req_ready;
        if (f) begin
            e.addr = bus.imem_req_addr;
            e.due  = cyc + lat;
            mq.push_back(e);
            fires++;
        end
        @(posedge clk);
        #1;
        cyc++;
        bus.imem_rsp_valid = 1'b0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = 32'h13 + mq[0].addr;
            void'(mq.pop_front());
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        mq.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
    endtask

    // Drains with if_ready=1, checking the delivered PCs/words follow exp_start in order.
    task automatic run_stream(input int ncyc, input logic [31:0] exp_start, input int min_cnt);
        logic [31:0] exp_pc;
        int          got;
        exp_pc = exp_start;
        got    = 0;
        bus.if_ready = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            if (bus.if_valid) begin
                chk("stream_pc", bus.if_pc, exp_pc);
                chk("stream_instr", bus.if_instr, 32'h13 + exp_pc);
                exp_pc = exp_pc + 32'd4;
                got++;
            end
            step();
        end
        n_total++;
        if (got < min_cnt) $display("FAIL stream_count: got %0d expected >= %0d", got, min_cnt);
        else n_pass++;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Steady stream at latency 1, then redirect coinciding with a response and a pop.
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0,   32'h0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h4,   1'b0, 32'h0,   32'h0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h0,   32'h13};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h4,   32'h17};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'hC,   1'b0, 32'h0,   32'h0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h8,   32'h1B};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'hC,   32'h1F};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h14,  1'b0, 32'h0,   32'h0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h10,  32'h23};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0,   32'h0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h4,   1'b0, 32'h0,   32'h0};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0,   1'b1, 32'h0,   32'h13};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0,   32'h0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h0,   32'h0};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h100, 32'h113};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h104, 32'h117};

        bus.imem_req_ready  = 1'b1;
        bus.imem_rsp_valid  = 1'b0;
        bus.imem_rsp_data   = 32'h0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 32'h0;
        bus.if_ready        = 1'b1;

        // Reset values, and no request in the cycle reset is released.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
        chk("rst_if_valid", 32'(bus.if_valid), 32'h0);
        chk("rst_if_pc", bus.if_pc, 32'h0);
        chk("rst_if_instr", bus.if_instr, 32'h0);
        chk("rst_fault", 32'(bus.misalign_fault), 32'h0);
        reset = 1'b0;
        cyc   = 0;
        chk("rel_req_valid", 32'(bus.imem_req_valid), 32'h0);

        lat = 1;
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].rst) do_reset();
            step();
            bus.if_ready        = vecs[i].rdy;
            bus.redirect_valid  = vecs[i].redir;
            bus.redirect_target = vecs[i].tgt;
            chk($sformatf("v%0d_req_valid", i), 32'(bus.imem_req_valid), 32'(vecs[i].exp_rv));
            if (vecs[i].exp_rv) chk($sformatf("v%0d_req_addr", i), bus.imem_req_addr, vecs[i].exp_addr);
            chk($sformatf("v%0d_if_valid", i), 32'(bus.if_valid), 32'(vecs[i].exp_ifv));
            if (vecs[i].exp_ifv) begin
                chk($sformatf("v%0d_if_pc", i), bus.if_pc, vecs[i].exp_pc);
                chk($sformatf("v%0d_if_instr", i), bus.if_instr, vecs[i].exp_instr);
            end
        end
        bus.redirect_valid = 1'b0;

        // Decode stalled: credit stops at FIFO_DEPTH requests, nothing lost.
        do_reset();
        bus.if_ready = 1'b0;
        fires = 0;
        repeat (10) step();
        chk("stall_fires", 32'(fires), 32'd2);
        chk("stall_req_valid", 32'(bus.imem_req_valid), 32'h0);
        chk("stall_if_pc", bus.if_pc, 32'h0);
        run_stream(12, 32'h0, 4);

        // Two requests in flight when redirect resolves: both responses discarded.
        lat = 3;
        do_reset();
        step();
        chk("fl2_addr0", bus.imem_req_addr, 32'h0);
        step();
        chk("fl2_addr4", bus.imem_req_addr, 32'h4);
        step();
        chk("fl2_credit_full", 32'(bus.imem_req_valid), 32'h0);
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h100;
        step();
        bus.redirect_valid = 1'b0;
        chk("fl2_if_valid", 32'(bus.if_valid), 32'h0);
        chk("fl2_wait_credit", 32'(bus.imem_req_valid), 32'h0);
        step();
        chk("fl2_req_valid", 32'(bus.imem_req_valid), 32'h1);
        chk("fl2_req_addr", bus.imem_req_addr, 32'h100);
        run_stream(15, 32'h100, 2);

        // Back-to-back redirects: the second target wins, drops accumulate.
        do_reset();
        step();
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h200;
        step();
        bus.redirect_target = 32'h300;
        chk("b2b_addr", bus.imem_req_addr, 32'h200);
        step();
        bus.redirect_valid = 1'b0;
        chk("b2b_credit", 32'(bus.imem_req_valid), 32'h0);
        run_stream(20, 32'h300, 2);

        // PC wrap at the top of the address space.
        lat = 1;
        do_reset();
        step();
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'hFFFF_FFFC;
        step();
        bus.redirect_valid = 1'b0;
        chk("wrap_addr_top", bus.imem_req_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap_req_valid", 32'(bus.imem_req_valid), 32'h1);
        chk("wrap_addr_zero", bus.imem_req_addr, 32'h0);
        run_stream(10, 32'hFFFF_FFFC, 3);

        // Misaligned redirect target.
        do_reset();
        step();
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h102;
        step();
        bus.redirect_valid = 1'b0;
`ifdef RV_FETCH_MISALIGN_TRAP_EN
        chk("mis_fault", 32'(bus.misalign_fault), 32'h1);
        chk("mis_req_valid", 32'(bus.imem_req_valid), 32'h0);
        repeat (5) step();
        chk("mis_fault_sticky", 32'(bus.misalign_fault), 32'h1);
        chk("mis_req_held", 32'(bus.imem_req_valid), 32'h0);
        chk("mis_if_valid", 32'(bus.if_valid), 32'h0);
`else
        chk("mis_fault_tied", 32'(bus.misalign_fault), 32'h0);
        chk("mis_req_addr", bus.imem_req_addr, 32'h100);
        run_stream(10, 32'h100, 3);
`endif
        do_reset();
        chk("mis_fault_cleared", 32'(bus.misalign_fault), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
